// File: rtl/axi_read_master.sv
// rtl/axi_read_master.sv - AXI4 read-channel initiator with one-entry beat output register
//
// Accepts one burst command at a time on a valid/ready port, issues the AR
// transaction, collects the INCR burst on R and presents each beat through a
// registered output stage. Protocol violations and error responses fold into
// rd_err, which is valid on the final beat.
//
// Ports:
//   ACLK, ARESETn                 clock, asynchronous active-low reset
//   req_valid/req_ready           command handshake
//   req_addr, req_len             byte start address, beats minus one
//   busy                          transaction in progress
//   rd_data/rd_valid/rd_ready     beat output stream
//   rd_last, rd_err               final beat marker, error summary on final beat
//   ARID..ARVALID, ARREADY        AXI read address channel
//   RID..RVALID, RREADY           AXI read data channel
module axi_read_master #(
   parameter logic [3:0] MASTER_ID  = 4'd0,
   parameter logic [2:0] BURST_SIZE = 3'b010
) (
   input  logic        ACLK,
   input  logic        ARESETn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [3:0]  req_len,
   output logic        busy,
   output logic [31:0] rd_data,
   output logic        rd_valid,
   output logic        rd_last,
   output logic        rd_err,
   input  logic        rd_ready,
   output logic [3:0]  ARID,
   output logic [31:0] ARADDR,
   output logic [3:0]  ARLEN,
   output logic [2:0]  ARSIZE,
   output logic [1:0]  ARBURST,
   output logic        ARVALID,
   input  logic        ARREADY,
   input  logic [3:0]  RID,
   input  logic [31:0] RDATA,
   input  logic [1:0]  RRESP,
   input  logic        RLAST,
   input  logic        RVALID,
   output logic        RREADY
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [31:0] araddr_q;
   logic [3:0]  arlen_q;
   logic [3:0]  cnt_q;
   logic        err_q;

   logic        cmd_acc;
   logic        ar_acc;
   logic        beat_acc;
   logic        at_end;
   logic        beat_err;
   logic        term;

   assign ARID    = MASTER_ID;
   assign ARSIZE  = BURST_SIZE;
   assign ARBURST = 2'b01;
   assign ARADDR  = araddr_q;
   assign ARLEN   = arlen_q;

   assign req_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign ARVALID   = (state_q == ADDR);
   // Depends only on state and the output register, never on RVALID.
   assign RREADY    = (state_q == DATA) && (!rd_valid || rd_ready);

   assign cmd_acc  = req_valid && req_ready;
   assign ar_acc   = ARVALID && ARREADY;
   assign beat_acc = RVALID && RREADY;
   assign at_end   = (cnt_q == arlen_q);

   // A beat is bad if it carries an error response, the wrong ID, or its
   // RLAST disagrees with our own beat count.
   assign beat_err = (RRESP != 2'b00) || (RID != MASTER_ID) ||
                     (RLAST && !at_end) || (!RLAST && at_end);

   // Stop on whichever of RLAST or the expected count arrives first, so a
   // missing or early RLAST never leaves the FSM stuck in DATA.
   assign term = RLAST || at_end;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cmd_acc) state_d = ADDR;
         ADDR:    if (ar_acc) state_d = DATA;
         DATA:    if (beat_acc && term) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         araddr_q <= 32'd0;
         arlen_q  <= 4'd0;
         cnt_q    <= 4'd0;
         err_q    <= 1'b0;
      end else if (cmd_acc) begin
         araddr_q <= req_addr & 32'hFFFF_FFFC;
         arlen_q  <= req_len;
         cnt_q    <= 4'd0;
         err_q    <= 1'b0;
      end else if (beat_acc) begin
         // The count stops at arlen_q, so it cannot wrap inside a burst.
         cnt_q <= cnt_q + 4'd1;
         err_q <= err_q | beat_err;
      end
   end

   // One-entry output register: a load and a drain in the same cycle keep
   // rd_valid high with the new beat.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         rd_data  <= 32'd0;
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
         rd_err   <= 1'b0;
      end else if (beat_acc) begin
         rd_data  <= RDATA;
         rd_valid <= 1'b1;
         rd_last  <= term;
         rd_err   <= term && (err_q || beat_err);
      end else if (rd_ready) begin
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
         rd_err   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axi_read_master.sv
// tb/tb_axi_read_master.sv - directed self-checking bench for axi_read_master
module tb_axi_read_master;

   logic        ACLK = 1'b0;
   logic        ARESETn;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [3:0]  req_len;
   logic        busy;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        rd_last;
   logic        rd_err;
   logic        rd_ready;
   logic [3:0]  ARID;
   logic [31:0] ARADDR;
   logic [3:0]  ARLEN;
   logic [2:0]  ARSIZE;
   logic [1:0]  ARBURST;
   logic        ARVALID;
   logic        ARREADY;
   logic [3:0]  RID;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RLAST;
   logic        RVALID;
   logic        RREADY;

   int errors = 0;
   int checks = 0;

   axi_read_master #(.MASTER_ID(4'd0), .BURST_SIZE(3'b010)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_len(req_len), .busy(busy),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
      .rd_err(rd_err), .rd_ready(rd_ready),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
      .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
      .RVALID(RVALID), .RREADY(RREADY)
   );

   always #5 ACLK = ~ACLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic cmd(input logic [31:0] addr, input logic [3:0] len, input logic [31:0] exp_addr);
      req_valid = 1'b1;
      req_addr  = addr;
      req_len   = len;
      #1;
      chk("cmd_req_ready", req_ready, 1);
      tick();
      req_valid = 1'b0;
      chk("cmd_arvalid", ARVALID, 1);
      chk("cmd_araddr", ARADDR, exp_addr);
      chk("cmd_arlen", ARLEN, len);
      ARREADY = 1'b1;
      tick();
      ARREADY = 1'b0;
   endtask

   task automatic send_beat(input logic [31:0] data, input logic last,
                            input logic [1:0] resp, input logic [3:0] id);
      RVALID = 1'b1;
      RDATA  = data;
      RLAST  = last;
      RRESP  = resp;
      RID    = id;
      #1;
      chk("beat_rready", RREADY, 1);
      tick();
      RVALID = 1'b0;
      RLAST  = 1'b0;
   endtask

   initial begin
      ARESETn   = 1'b0;
      req_valid = 1'b0;
      req_addr  = 32'd0;
      req_len   = 4'd0;
      rd_ready  = 1'b0;
      ARREADY   = 1'b0;
      RID       = 4'd0;
      RDATA     = 32'd0;
      RRESP     = 2'b00;
      RLAST     = 1'b0;
      RVALID    = 1'b0;
      tick();
      tick();

      // Reset state
      chk("rst_arvalid", ARVALID, 0);
      chk("rst_rready", RREADY, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_last", rd_last, 0);
      chk("rst_rd_err", rd_err, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_araddr", ARADDR, 0);
      chk("rst_arlen", ARLEN, 0);
      chk("rst_busy", busy, 0);
      chk("rst_req_ready", req_ready, 1);
      ARESETn = 1'b1;
      tick();

      // Single beat, unaligned address, ARREADY delayed by two cycles
      req_valid = 1'b1;
      req_addr  = 32'h0000_1006;
      req_len   = 4'd0;
      tick();
      req_valid = 1'b0;
      chk("s1_arvalid", ARVALID, 1);
      chk("s1_araddr", ARADDR, 32'h0000_1004);
      chk("s1_arlen", ARLEN, 0);
      chk("s1_arburst", ARBURST, 1);
      chk("s1_arsize", ARSIZE, 2);
      chk("s1_arid", ARID, 0);
      chk("s1_busy", busy, 1);
      chk("s1_req_ready", req_ready, 0);
      tick();
      chk("s1_arvalid_hold", ARVALID, 1);
      chk("s1_araddr_hold", ARADDR, 32'h0000_1004);
      tick();
      ARREADY = 1'b1;
      tick();
      ARREADY = 1'b0;
      chk("s1_arvalid_done", ARVALID, 0);
      rd_ready = 1'b1;
      send_beat(32'hDEAD_BEEF, 1'b1, 2'b00, 4'd0);
      chk("s1_rd_valid", rd_valid, 1);
      chk("s1_rd_data", rd_data, 32'hDEAD_BEEF);
      chk("s1_rd_last", rd_last, 1);
      chk("s1_rd_err", rd_err, 0);
      chk("s1_idle_req_ready", req_ready, 1);
      chk("s1_idle_rready", RREADY, 0);
      tick();
      chk("s1_drained", rd_valid, 0);

      // 16-beat burst at full throughput
      cmd(32'h0000_2000, 4'd15, 32'h0000_2000);
      for (int i = 0; i < 16; i++) begin
         send_beat(32'h0000_1000 + i, (i == 15), 2'b00, 4'd0);
         chk("b16_rd_valid", rd_valid, 1);
         chk("b16_rd_data", rd_data, 32'h0000_1000 + i);
         chk("b16_rd_last", rd_last, (i == 15));
      end
      chk("b16_rd_err", rd_err, 0);
      chk("b16_idle", req_ready, 1);
      tick();

      // Backpressure: consumer stalls three cycles after beat 1
      cmd(32'h0000_3000, 4'd3, 32'h0000_3000);
      send_beat(32'hA000_0000, 1'b0, 2'b00, 4'd0);
      chk("bp_beat0", rd_data, 32'hA000_0000);
      rd_ready = 1'b0;
      RVALID   = 1'b1;
      RDATA    = 32'hA000_0001;
      #1;
      chk("bp_rready_low", RREADY, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_hold_valid", rd_valid, 1);
         chk("bp_hold_data", rd_data, 32'hA000_0000);
         chk("bp_hold_rready", RREADY, 0);
      end
      rd_ready = 1'b1;
      #1;
      chk("bp_rready_high", RREADY, 1);
      tick();
      RVALID = 1'b0;
      chk("bp_beat1", rd_data, 32'hA000_0001);
      chk("bp_beat1_valid", rd_valid, 1);
      send_beat(32'hA000_0002, 1'b0, 2'b00, 4'd0);
      chk("bp_beat2", rd_data, 32'hA000_0002);
      send_beat(32'hA000_0003, 1'b1, 2'b00, 4'd0);
      chk("bp_beat3", rd_data, 32'hA000_0003);
      chk("bp_last", rd_last, 1);
      chk("bp_err", rd_err, 0);
      tick();

      // SLVERR on beat 2 of 4 is reported on beat 4
      cmd(32'h0000_4000, 4'd3, 32'h0000_4000);
      for (int i = 0; i < 4; i++) begin
         send_beat(32'hB000_0000 + i, (i == 3), (i == 1) ? 2'b10 : 2'b00, 4'd0);
         chk("resp_data", rd_data, 32'hB000_0000 + i);
      end
      chk("resp_last", rd_last, 1);
      chk("resp_err", rd_err, 1);
      tick();

      // Wrong RID
      cmd(32'h0000_5000, 4'd1, 32'h0000_5000);
      send_beat(32'hC000_0000, 1'b0, 2'b00, 4'd5);
      send_beat(32'hC000_0001, 1'b1, 2'b00, 4'd0);
      chk("rid_last", rd_last, 1);
      chk("rid_err", rd_err, 1);
      tick();

      // Early RLAST on beat 2 of 4 ends the burst there
      cmd(32'h0000_6000, 4'd3, 32'h0000_6000);
      send_beat(32'hD000_0000, 1'b0, 2'b00, 4'd0);
      chk("early_mid_last", rd_last, 0);
      send_beat(32'hD000_0001, 1'b1, 2'b00, 4'd0);
      chk("early_data", rd_data, 32'hD000_0001);
      chk("early_last", rd_last, 1);
      chk("early_err", rd_err, 1);
      chk("early_idle", req_ready, 1);
      RVALID = 1'b1;
      #1;
      chk("early_no_accept", RREADY, 0);
      RVALID = 1'b0;
      tick();

      // Missing RLAST: counter terminates the burst
      cmd(32'h0000_7000, 4'd1, 32'h0000_7000);
      send_beat(32'hE000_0000, 1'b0, 2'b00, 4'd0);
      send_beat(32'hE000_0001, 1'b0, 2'b00, 4'd0);
      chk("nolast_last", rd_last, 1);
      chk("nolast_err", rd_err, 1);
      chk("nolast_req_ready", req_ready, 1);
      chk("nolast_busy", busy, 0);
      tick();

      // Reset mid-burst after beat 2 of 8, then a clean burst
      cmd(32'h0000_8000, 4'd7, 32'h0000_8000);
      send_beat(32'hF000_0000, 1'b0, 2'b00, 4'd0);
      send_beat(32'hF000_0001, 1'b0, 2'b00, 4'd0);
      #2;
      ARESETn = 1'b0;
      #1;
      chk("mrst_rd_valid", rd_valid, 0);
      chk("mrst_rd_data", rd_data, 0);
      chk("mrst_rready", RREADY, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_araddr", ARADDR, 0);
      chk("mrst_arlen", ARLEN, 0);
      chk("mrst_req_ready", req_ready, 1);
      tick();
      ARESETn = 1'b1;
      tick();
      cmd(32'h0000_900A, 4'd0, 32'h0000_9008);
      send_beat(32'h55AA_55AA, 1'b1, 2'b00, 4'd0);
      chk("post_data", rd_data, 32'h55AA_55AA);
      chk("post_last", rd_last, 1);
      chk("post_err", rd_err, 0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axi_read_master.md
# axi_read_master

Single-clock AXI4 read-channel initiator: the requesting end of the AR/R handshake that our ROM/SRAM read slaves answer. It accepts one burst request at a time from a simple valid/ready command port, issues the AR transaction, collects the INCR burst on R, and streams beats to the consumer through a one-entry output register. Protocol violations and error responses are flagged on the final beat. It sits between a CPU-side fetch or load unit and the AXI interconnect master port.

## Interface
Parameters:
- MASTER_ID, 4'd0, value driven on ARID and expected on RID
- BURST_SIZE, 3'b010, value driven on ARSIZE (4-byte beats)

Ports:
- ACLK  in  1  clock; all logic on rising edge
- ARESETn  in  1  reset, asynchronous, active-low
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when req_valid && req_ready
- req_addr  in  32  byte start address
- req_len  in  4  beats minus one (0–15)
- busy  out  1  transaction in progress (state != IDLE)
- rd_data  out  32  beat data
- rd_valid  out  1  beat valid
- rd_last  out  1  final beat of the burst
- rd_err  out  1  error summary, meaningful only with rd_valid && rd_last
- rd_ready  in  1  consumer accepts beat
- ARID  out  4, ARADDR  out  32, ARLEN  out  4, ARSIZE  out  3, ARBURST  out  2, ARVALID  out  1
- ARREADY  in  1
- RID  in  4, RDATA  in  32, RRESP  in  2, RLAST  in  1, RVALID  in  1
- RREADY  out  1

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE: req_ready=1. On a command handshake, latch {req_addr[31:2],2'b00} into ARADDR, req_len into ARLEN; clear beat counter and error flag; go to ADDR.
- ADDR: ARVALID=1, all AR fields stable until ARREADY. On ARVALID && ARREADY go to DATA.
- Constant fields: ARID=MASTER_ID, ARSIZE=BURST_SIZE, ARBURST=2'b01 (INCR).
- DATA: RREADY = !rd_valid || rd_ready (output register empty or draining this cycle). Beat accepted on RVALID && RREADY.
- Each accepted beat loads rd_data<=RDATA, rd_valid<=1, increments the 4-bit beat counter.
- Error flag set (sticky for the transaction) when on any accepted beat: RRESP!=2'b00, RID!=MASTER_ID, RLAST=1 with counter!=ARLEN, or RLAST=0 with counter==ARLEN.
- Burst terminates on the accepted beat where RLAST=1 or counter==ARLEN, whichever comes first; that beat loads rd_last=1 and rd_err=(flag OR this beat's error); FSM returns to IDLE.
- rd_valid clears on rd_ready when no new beat is loaded the same cycle; simultaneous drain and load keeps rd_valid=1 with new data.
- Beats arriving after termination are not accepted (RREADY=0 outside DATA); recovery is the interconnect's responsibility.
- Counter never wraps within a burst: max value 15 equals max ARLEN.

## Timing
- Reset (async assert, sync to ACLK on release): state=IDLE; ARVALID=0, RREADY=0, rd_valid=0, rd_last=0, rd_err=0, rd_data=0, ARADDR=0, ARLEN=0, busy=0, req_ready=1.
- Reset asserted mid-burst aborts immediately; no beat is delivered.
- Command handshake at edge N -> ARVALID=1 from cycle N+1.
- AR handshake at edge M -> RREADY may be 1 from cycle M+1.
- R handshake at edge K -> rd_valid=1 with that data from cycle K+1 (1-cycle latency).
- Next command accepted earliest in the cycle after the last beat is accepted; output register may still hold the last beat (rd_valid=1) concurrently.
- Full throughput: 1 beat/cycle with rd_ready held high.
- req_ready and RREADY are combinational from state and output register; no combinational path from RVALID to RREADY.

## Test plan
- Single beat: req_addr=0x0000_1006, req_len=0, ARREADY after 2 cycles, one R beat RDATA=0xDEADBEEF RLAST=1 -> ARADDR=0x0000_1004, ARLEN=0, ARBURST=1, ARSIZE=2; rd_data=0xDEADBEEF, rd_last=1, rd_err=0 one cycle after R handshake.
- 16-beat burst, RVALID every cycle, rd_ready=1 -> 16 consecutive rd_valid cycles, data in order, rd_last only on beat 16, RREADY never drops.
- Backpressure: 4-beat burst, rd_ready low for 3 cycles after beat 1 -> RREADY=0 while rd_valid && !rd_ready; no beat lost or duplicated.
- Errors: RRESP=2'b10 on beat 2 of 4 -> rd_err=1 on beat 4; separately RID=4'd5 -> rd_err=1; RLAST on beat 2 of 4 -> burst ends with rd_last at beat 2, rd_err=1.
- Missing RLAST: req_len=1, RLAST=0 on beat 2 -> burst terminates at beat 2 with rd_err=1; FSM IDLE, req_ready=1.
- Reset mid-burst: ARESETn low after beat 2 of 8 -> all outputs at reset values asynchronously; new command after release completes normally.
